// File: rtl/chacha_ks_prefetch_unit.sv
// chacha_ks_prefetch_unit: ChaCha keystream prefetcher streaming OUT_W-bit slices from a block FIFO

// Iterative ChaCha20 block core: one double round per cycle, output serialised MSB-byte first
module chacha_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         init,
   input  logic         next,
   input  logic [255:0] key,
   input  logic [63:0]  iv,
   input  logic [63:0]  ctr,
   input  logic [511:0] data_in,
   output logic         ready,
   output logic [511:0] data_out,
   output logic         data_valid
);
   logic [511:0] s0, x, x_init, x_dr, ks;
   logic [3:0]   rnd;
   logic         run;

   function automatic logic [31:0] bswap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [127:0] qr(input logic [127:0] q);
      logic [31:0] a, b, c, d;
      {a, b, c, d} = q;
      a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
      c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
      a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
      c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
      return {a, b, c, d};
   endfunction

   // column round followed by diagonal round; word i lives at bits [32*i +: 32]
   function automatic logic [511:0] dround(input logic [511:0] s);
      logic [31:0]  w [16];
      logic [511:0] r;
      for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
      for (int i = 0; i < 8; i++) begin
         int a, b, c, d;
         a = i % 4;
         b = (i < 4) ? a + 4  : 4  + (a + 1) % 4;
         c = (i < 4) ? a + 8  : 8  + (a + 2) % 4;
         d = (i < 4) ? a + 12 : 12 + (a + 3) % 4;
         {w[a], w[b], w[c], w[d]} = qr({w[a], w[b], w[c], w[d]});
      end
      r = '0;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
      return r;
   endfunction

   assign x_dr  = dround(x);
   assign ready = !run;

   // initial state: word 12 is the block counter, words 13..15 carry the nonce in byte order
   always_comb begin
      s0 = '0;
      s0[127:0] = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
      for (int i = 0; i < 8; i++) s0[128 + 32*i +: 32] = bswap(key[255 - 32*i -: 32]);
      s0[415:384] = ctr[63:32];
      s0[447:416] = bswap(iv[63:32]);
      s0[479:448] = bswap(iv[31:0]);
      s0[511:480] = bswap(ctr[31:0]);
   end

   // feed-forward add and little-endian serialisation of the final round
   always_comb begin
      ks = '0;
      for (int i = 0; i < 16; i++) ks[511 - 32*i -: 32] = bswap(x_dr[32*i +: 32] + x_init[32*i +: 32]);
   end

   // round iteration; result held with data_valid until the next start
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         x          <= '0;
         x_init     <= '0;
         rnd        <= '0;
         run        <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (init | next) begin
         x          <= s0;
         x_init     <= s0;
         rnd        <= '0;
         run        <= 1'b1;
         data_valid <= 1'b0;
      end else if (run) begin
         x   <= x_dr;
         rnd <= rnd + 4'd1;
         if (rnd == 4'd9) begin
            run        <= 1'b0;
            data_valid <= 1'b1;
            data_out   <= ks ^ data_in;
         end
      end
endmodule

module chacha_ks_prefetch_unit #(
   parameter int OUT_W = 128,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_we,
   input  logic [255:0]               chacha_key,
   input  logic [95:0]                chacha_nonce,
   input  logic [31:0]                chacha_ctr_init,
   input  logic                       ks_en,
   output logic                       ks_valid,
   input  logic                       ks_ready,
   output logic [OUT_W-1:0]           ks_data,
   output logic                       ks_last,
   output logic [31:0]                ks_blk_ctr,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic                       busy,
   output logic                       ctr_exhausted
);
   localparam int SLICES = 512 / OUT_W;
   localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW     = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

   state_t         state, state_nx;
   logic [255:0]   key_reg;
   logic [95:0]    nonce_reg;
   logic [31:0]    ctr_reg;
   logic           first;
   logic           core_ready, core_valid, blk_done, push, pop, adv;
   logic [511:0]   core_data, head;
   logic [511:0]   blk_mem [2**PW];
   logic [31:0]    ctr_mem [2**PW];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [SW-1:0]  idx;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   chacha_core u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .init       (state == ISSUE),
      .next       (1'b0),
      .key        (key_reg),
      .iv         (nonce_reg[95:32]),
      .ctr        ({ctr_reg, nonce_reg[31:0]}),
      .data_in    ('0),
      .ready      (core_ready),
      .data_out   (core_data),
      .data_valid (core_valid)
   );

   // the core's valid is not trusted in the cycle right after init
   assign blk_done = core_valid && !first;
   assign push     = (state == WAIT) && blk_done && !cfg_we;
   assign adv      = ks_valid && ks_ready && !cfg_we;
   assign pop      = adv && ks_last;
   assign busy     = state != IDLE;

   // next-state: only IDLE can issue, and only with room for the block it will produce
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (!cfg_we && ks_en && core_ready && !ctr_exhausted && int'(fifo_level) < DEPTH) ? ISSUE : IDLE;
         ISSUE:   state_nx = cfg_we ? DRAIN : WAIT;
         WAIT:    state_nx = blk_done ? IDLE : cfg_we ? DRAIN : WAIT;
         DRAIN:   state_nx = blk_done ? IDLE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end

   // FSM state, config registers and counter advance on each stored block
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         first         <= 1'b0;
         key_reg       <= '0;
         nonce_reg     <= '0;
         ctr_reg       <= '0;
         ctr_exhausted <= 1'b0;
      end else begin
         state <= state_nx;
         first <= state == ISSUE;
         if (cfg_we) begin
            key_reg       <= chacha_key;
            nonce_reg     <= chacha_nonce;
            ctr_reg       <= chacha_ctr_init;
            ctr_exhausted <= 1'b0;
         end else if (push) begin
            if (ctr_reg == '1) ctr_exhausted <= 1'b1;
            else ctr_reg <= ctr_reg + 32'd1;
         end
      end

   // FIFO pointers, occupancy and slice index; cfg_we flushes everything
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         idx        <= '0;
      end else if (cfg_we) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         idx        <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop) rd_ptr <= nxt(rd_ptr);
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
         if (adv) idx <= ks_last ? '0 : idx + SW'(1);
      end

   // block storage; contents are only observed through ks_valid-gated outputs
   always_ff @(posedge clk)
      if (push) begin
         blk_mem[wr_ptr] <= core_data;
         ctr_mem[wr_ptr] <= ctr_reg;
      end

   // presentation of the head slice, zero while the FIFO is empty
   always_comb begin
      head       = blk_mem[rd_ptr];
      ks_valid   = fifo_level != '0;
      ks_last    = ks_valid && int'(idx) == SLICES - 1;
      ks_data    = ks_valid ? head[511 - OUT_W*int'(idx) -: OUT_W] : '0;
      ks_blk_ctr = ks_valid ? ctr_mem[rd_ptr] : '0;
   end
endmodule

// File: tb/tb_chacha_ks_prefetch_unit.sv
// tb_chacha_ks_prefetch_unit: directed and randomized checks against an RFC-style ChaCha20 model
module tb_chacha_ks_prefetch_unit;
   logic         clk = 1'b0;
   logic         rst_n, rst_n2;
   logic         cfg_we, cfg_we2, ks_en, ks_en2, ks_ready, ks_ready2;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic [31:0]  ctr_init;
   logic         ks_valid, ks_last, busy, ctr_exhausted;
   logic [127:0] ks_data;
   logic [31:0]  ks_blk_ctr;
   logic [1:0]   fifo_level;
   logic         v2, l2, busy2, exh2;
   logic [511:0] d2;
   logic [31:0]  c2;
   logic [0:0]   lvl2;
   int           checks = 0, passes = 0, fails = 0;

   localparam logic [511:0] RFC_BLK = 512'h10f1e7e4d13b5915500fdd1fa32071c4c7d1f4c733c068030422aa9ac3d46c4ed2826446079faa0914c2d705d98b02a2b5129cd1de164eb9cbd083e8a2503c4e;

   always #5 clk = ~clk;

   chacha_ks_prefetch_unit #(.OUT_W(128), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .chacha_key(key), .chacha_nonce(nonce),
      .chacha_ctr_init(ctr_init), .ks_en(ks_en), .ks_valid(ks_valid), .ks_ready(ks_ready),
      .ks_data(ks_data), .ks_last(ks_last), .ks_blk_ctr(ks_blk_ctr), .fifo_level(fifo_level),
      .busy(busy), .ctr_exhausted(ctr_exhausted)
   );

   chacha_ks_prefetch_unit #(.OUT_W(512), .DEPTH(1)) dut2 (
      .clk(clk), .rst_n(rst_n2), .cfg_we(cfg_we2), .chacha_key(key), .chacha_nonce(nonce),
      .chacha_ctr_init(ctr_init), .ks_en(ks_en2), .ks_valid(v2), .ks_ready(ks_ready2),
      .ks_data(d2), .ks_last(l2), .ks_blk_ctr(c2), .fifo_level(lvl2),
      .busy(busy2), .ctr_exhausted(exh2)
   );

   function automatic logic [31:0] le(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
      return (v << s) | (v >> (32 - s));
   endfunction

   // keystream block as a byte string: key, counter word, 96-bit nonce, 20 rounds, feed-forward
   function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
      logic [31:0]  s [16];
      logic [31:0]  w [16];
      logic [511:0] r;
      int qa [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int qb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
      int qc [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
      int qd [8] = '{12, 13, 14, 15, 15, 12, 13, 14};
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4+i] = le(k[255 - 32*i -: 32]);
      s[12] = c;
      for (int i = 0; i < 3; i++) s[13+i] = le(n[95 - 32*i -: 32]);
      w = s;
      for (int q = 0; q < 80; q++) begin
         int a, b, cc, d;
         a = qa[q % 8]; b = qb[q % 8]; cc = qc[q % 8]; d = qd[q % 8];
         w[a] = w[a] + w[b]; w[d] = rotl(w[d] ^ w[a], 16);
         w[cc] = w[cc] + w[d]; w[b] = rotl(w[b] ^ w[cc], 12);
         w[a] = w[a] + w[b]; w[d] = rotl(w[d] ^ w[a], 8);
         w[cc] = w[cc] + w[d]; w[b] = rotl(w[b] ^ w[cc], 7);
      end
      for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = le(w[i] + s[i]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cfg(input logic [31:0] c);
      @(negedge clk);
      ctr_init = c;
      cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic cfg2(input logic [31:0] c);
      @(negedge clk);
      ctr_init = c;
      cfg_we2 = 1'b1;
      @(negedge clk);
      cfg_we2 = 1'b0;
   endtask

   // collect four slices of one block, optionally with random back-pressure
   task automatic get_block(input bit rnd, output logic [511:0] blk, output logic [31:0] c);
      int n = 0, t = 0;
      bit held = 0;
      logic [160:0] hold;
      blk = '0;
      c = '0;
      while (n < 4 && t < 600) begin
         @(negedge clk);
         t++;
         if (held) chk("stall_hold", {ks_last, ks_blk_ctr, ks_data}, hold);
         held = 0;
         ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ks_valid) begin
            if (n == 0) c = ks_blk_ctr;
            else chk("beat_ctr", ks_blk_ctr, c);
            chk("beat_last", ks_last, n == 3);
            blk[511 - 128*n -: 128] = ks_data;
            if (ks_ready) n++;
            else begin
               held = 1;
               hold = {ks_last, ks_blk_ctr, ks_data};
            end
         end
      end
      if (n < 4) chk("block_timeout", n, 4);
      @(posedge clk);
      #1 ks_ready = 1'b0;
   endtask

   initial begin
      logic [511:0] blk;
      logic [31:0]  c, base;
      logic [255:0] key1;
      logic [95:0]  nonce1;
      int t;
      rst_n = 0; rst_n2 = 0; cfg_we = 0; cfg_we2 = 0; ks_en = 0; ks_en2 = 0;
      ks_ready = 0; ks_ready2 = 0; key = '0; nonce = '0; ctr_init = '0;
      repeat (3) @(negedge clk);
      rst_n = 1; rst_n2 = 1;
      @(negedge clk);
      chk("rst_data", ks_data, '0);
      chk("rst_ctl", {ks_valid, ks_last, ks_blk_ctr, fifo_level, busy, ctr_exhausted}, '0);

      // RFC 7539 block function vector
      key1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      nonce1 = 96'h000000090000004a00000000;
      key = key1; nonce = nonce1;
      cfg(32'd1);
      ks_en = 1;
      get_block(0, blk, c);
      chk("t1_ctr", c, 32'd1);
      chk("t1_rfc", blk, RFC_BLK);
      chk("t1_model", blk, chacha_ref(key1, nonce1, 32'd1));

      // back-pressure fills the FIFO to DEPTH and generation stops
      cfg(32'd1);
      t = 0;
      while (!(fifo_level == 2 && !busy) && t < 300) begin @(negedge clk); t++; end
      chk("t2_level", fifo_level, 2);
      chk("t2_busy", busy, 0);
      repeat (40) @(negedge clk);
      chk("t2_hold", {fifo_level, busy, ks_blk_ctr}, {2'd2, 1'b0, 32'd1});
      get_block(0, blk, c);
      chk("t2_ctr1", c, 32'd1);
      t = 0;
      while (!busy && t < 10) begin @(negedge clk); t++; end
      chk("t2_reissue", busy, 1);
      get_block(0, blk, c);
      chk("t2_ctr2", c, 32'd2);
      chk("t2_blk2", blk, chacha_ref(key1, nonce1, 32'd2));
      get_block(0, blk, c);
      chk("t2_ctr3", c, 32'd3);
      chk("t2_blk3", blk, chacha_ref(key1, nonce1, 32'd3));

      // counter exhaustion
      cfg(32'hFFFFFFFE);
      get_block(0, blk, c);
      chk("t3_ctr_e", c, 32'hFFFFFFFE);
      chk("t3_blk_e", blk, chacha_ref(key1, nonce1, 32'hFFFFFFFE));
      get_block(0, blk, c);
      chk("t3_ctr_f", c, 32'hFFFFFFFF);
      chk("t3_blk_f", blk, chacha_ref(key1, nonce1, 32'hFFFFFFFF));
      repeat (40) @(negedge clk);
      chk("t3_exh", {ctr_exhausted, ks_valid, busy, fifo_level}, {1'b1, 1'b0, 1'b0, 2'd0});
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nonce = {$urandom, $urandom, $urandom};
      cfg(32'd5);
      chk("t3_clear", ctr_exhausted, 0);

      // reconfigure while a block is in flight
      repeat (4) @(negedge clk);
      chk("t4_inflight", busy, 1);
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nonce = {$urandom, $urandom, $urandom};
      cfg(32'd100);
      chk("t4_flush", {ks_valid, fifo_level}, '0);
      get_block(0, blk, c);
      chk("t4_ctr", c, 32'd100);
      chk("t4_blk", blk, chacha_ref(key, nonce, 32'd100));

      // random back-pressure over 16 blocks
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nonce = {$urandom, $urandom, $urandom};
      base = 32'($urandom_range(0, 32'h7fffffff));
      cfg(base);
      for (int i = 0; i < 16; i++) begin
         get_block(1, blk, c);
         chk("t5_ctr", c, base + 32'(i));
         chk("t5_blk", blk, chacha_ref(key, nonce, base + 32'(i)));
      end
      ks_en = 0;

      // single-beat configuration and asynchronous reset mid-generation
      key = key1; nonce = nonce1;
      cfg2(32'd1);
      ks_en2 = 1;
      repeat (5) @(negedge clk);
      chk("t6_busy", {busy2, v2}, {1'b1, 1'b0});
      rst_n2 = 0;
      ks_en2 = 0;
      @(posedge clk);
      #1;
      chk("t6_rst_data", d2, '0);
      chk("t6_rst_ctl", {v2, l2, c2, lvl2, busy2, exh2}, '0);
      @(negedge clk);
      rst_n2 = 1;
      cfg2(32'd7);
      ks_en2 = 1;
      t = 0;
      while (!v2 && t < 100) begin @(negedge clk); t++; end
      chk("t6_beat7", {v2, l2, c2}, {1'b1, 1'b1, 32'd7});
      chk("t6_blk7", d2, chacha_ref(key1, nonce1, 32'd7));
      ks_ready2 = 1;
      @(negedge clk);
      ks_ready2 = 0;
      t = 0;
      while (!v2 && t < 100) begin @(negedge clk); t++; end
      chk("t6_beat8", {v2, l2, c2}, {1'b1, 1'b1, 32'd8});
      chk("t6_blk8", d2, chacha_ref(key1, nonce1, 32'd8));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
